// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution and fetch-PC sequencer.
// Resolves conditional branches, JAL and JALR, then redirects fetch or raises a misaligned-target trap.
module branch_resolve_unit #(
   parameter int               dataW   = 32,
   parameter logic [dataW-1:0] resetPC = '0
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             stall,
   input  logic             brValid,
   output logic             brReady,
   input  logic [2:0]       funct3,
   input  logic             jump,
   input  logic             jumpReg,
   input  logic [dataW-1:0] brPC,
   input  logic [dataW-1:0] rs1,
   input  logic [dataW-1:0] offset,
   input  logic             EQ,
   input  logic             NE,
   input  logic             LT,
   input  logic             LTU,
   input  logic             GE,
   input  logic             UGE,
   input  logic             trapAck,
   output logic [dataW-1:0] pc,
   output logic             flush,
   output logic             taken,
   output logic [dataW-1:0] linkAddr,
   output logic             misaligned
);

   typedef enum logic [1:0] {RUN, REDIRECT, TRAP} state_t;

   state_t           state;
   logic             cond;
   logic             take_req;
   logic             accept;
   logic [dataW-1:0] jr_sum;
   logic [dataW-1:0] target;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = EQ;
         3'b001:  cond = NE;
         3'b100:  cond = LT;
         3'b101:  cond = GE;
         3'b110:  cond = LTU;
         3'b111:  cond = UGE;
         default: cond = 1'b0;
      endcase
   end

   // JALR clears bit 0 of its sum; all sums wrap silently
   assign jr_sum   = rs1 + offset;
   assign target   = jumpReg ? (jr_sum & ~dataW'(1)) : (brPC + offset);
   assign take_req = jump | jumpReg | cond;
   assign brReady  = (state == RUN);
   assign accept   = brValid & brReady;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state      <= RUN;
         pc         <= resetPC;
         flush      <= 1'b0;
         taken      <= 1'b0;
         linkAddr   <= '0;
         misaligned <= 1'b0;
      end else begin
         flush <= 1'b0;
         taken <= 1'b0;
         case (state)
            RUN: begin
               if (accept && (jump || jumpReg))
                  linkAddr <= brPC + dataW'(4);
               // a taken request overrides stall
               if (accept && take_req) begin
                  taken <= 1'b1;
                  flush <= 1'b1;
                  if (target[1]) begin
                     state      <= TRAP;
                     misaligned <= 1'b1;
                  end else begin
                     state <= REDIRECT;
                     pc    <= target;
                  end
               end else if (!stall) begin
                  pc <= pc + dataW'(4);
               end
            end
            REDIRECT: state <= RUN;
            TRAP: begin
               if (trapAck) begin
                  state      <= RUN;
                  misaligned <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table of single requests
// plus hand sequences for reset, trap blocking and reset during redirect.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        nReset, stall, brValid, brReady;
   logic [2:0]  funct3;
   logic        jump, jumpReg;
   logic [31:0] brPC, rs1, offset;
   logic        EQ, NE, LT, LTU, GE, UGE, trapAck;
   logic [31:0] pc, linkAddr;
   logic        flush, taken, misaligned;

   int checks = 0;
   int errors = 0;

   branch_resolve_unit dut (
      .clk(clk), .nReset(nReset), .stall(stall), .brValid(brValid), .brReady(brReady),
      .funct3(funct3), .jump(jump), .jumpReg(jumpReg), .brPC(brPC), .rs1(rs1),
      .offset(offset), .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .UGE(UGE),
      .trapAck(trapAck), .pc(pc), .flush(flush), .taken(taken), .linkAddr(linkAddr),
      .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   // flg = {EQ, NE, LT, LTU, GE, UGE}
   typedef struct {
      logic        stl;
      logic [2:0]  f3;
      logic        jmp;
      logic        jr;
      logic [5:0]  flg;
      logic [31:0] bpc;
      logic [31:0] rs;
      logic [31:0] off;
      logic        etk;
      logic        emis;
      logic [31:0] etgt;
      logic [31:0] elink;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic stl, logic [2:0] f3, logic jmp, logic jr, logic [5:0] flg,
                               logic [31:0] bpc, logic [31:0] rs, logic [31:0] off,
                               logic etk, logic emis, logic [31:0] etgt, logic [31:0] elink);
      vec_t v;
      v.stl = stl; v.f3 = f3; v.jmp = jmp; v.jr = jr; v.flg = flg;
      v.bpc = bpc; v.rs = rs; v.off = off;
      v.etk = etk; v.emis = emis; v.etgt = etgt; v.elink = elink;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      brValid = 0; jump = 0; jumpReg = 0; funct3 = 3'b000; stall = 0; trapAck = 0;
      {EQ, NE, LT, LTU, GE, UGE} = 6'b0;
      brPC = '0; rs1 = '0; offset = '0;
   endtask

   task automatic apply(input vec_t v);
      brValid = 1; stall = v.stl; funct3 = v.f3; jump = v.jmp; jumpReg = v.jr;
      {EQ, NE, LT, LTU, GE, UGE} = v.flg;
      brPC = v.bpc; rs1 = v.rs; offset = v.off;
   endtask

   initial begin
      logic [31:0] exp_pc;
      vec_t v;

      //           stl f3      jmp jr flg        brPC          rs1         offset        tk mis target        link
      tbl.push_back(mk(0, 3'b000, 0, 0, 6'b100000, 32'h100,      32'h0,     32'h20,       1, 0, 32'h120,      32'h0));
      tbl.push_back(mk(0, 3'b000, 0, 0, 6'b011111, 32'h100,      32'h0,     32'h20,       0, 0, 32'h0,        32'h0));
      tbl.push_back(mk(0, 3'b001, 0, 0, 6'b010000, 32'h200,      32'h0,     32'hFFFF_FFF0,1, 0, 32'h1F0,      32'h0));
      tbl.push_back(mk(0, 3'b100, 0, 0, 6'b001000, 32'h40,       32'h0,     32'h10,       1, 0, 32'h50,       32'h0));
      tbl.push_back(mk(0, 3'b101, 0, 0, 6'b110101, 32'h40,       32'h0,     32'h10,       0, 0, 32'h0,        32'h0));
      tbl.push_back(mk(0, 3'b110, 0, 0, 6'b001000, 32'h80,       32'h0,     32'h40,       0, 0, 32'h0,        32'h0));
      tbl.push_back(mk(0, 3'b111, 0, 0, 6'b000001, 32'h300,      32'h0,     32'h4,        1, 0, 32'h304,      32'h0));
      tbl.push_back(mk(0, 3'b010, 0, 0, 6'b111111, 32'h300,      32'h0,     32'h4,        0, 0, 32'h0,        32'h0));
      tbl.push_back(mk(0, 3'b011, 0, 0, 6'b111111, 32'h300,      32'h0,     32'h4,        0, 0, 32'h0,        32'h0));
      tbl.push_back(mk(1, 3'b000, 0, 0, 6'b000000, 32'h300,      32'h0,     32'h4,        0, 0, 32'h0,        32'h0));
      tbl.push_back(mk(0, 3'b010, 1, 0, 6'b000000, 32'h80,       32'h0,     32'h100,      1, 0, 32'h180,      32'h84));
      tbl.push_back(mk(0, 3'b000, 0, 1, 6'b000000, 32'h500,      32'h1001,  32'h10,       1, 0, 32'h1010,     32'h504));
      tbl.push_back(mk(0, 3'b000, 1, 1, 6'b000000, 32'h600,      32'h2000,  32'h8,        1, 0, 32'h2008,     32'h604));
      tbl.push_back(mk(0, 3'b000, 0, 0, 6'b100000, 32'h100,      32'h0,     32'h2,        1, 1, 32'h102,      32'h604));
      tbl.push_back(mk(0, 3'b000, 0, 1, 6'b000000, 32'h700,      32'h203,   32'h0,        1, 1, 32'h202,      32'h704));
      tbl.push_back(mk(1, 3'b000, 1, 0, 6'b000000, 32'hFFFF_FFFC,32'h0,     32'h8,        1, 0, 32'h4,        32'h0));

      idle();
      nReset = 0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_pc", pc, 32'h0);
      chk("rst_flush", {31'b0, flush}, 32'h0);
      chk("rst_taken", {31'b0, taken}, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'h0);
      chk("rst_link", linkAddr, 32'h0);
      chk("rst_ready", {31'b0, brReady}, 32'h1);
      nReset = 1;

      exp_pc = 32'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         exp_pc += 32'h4;
         chk($sformatf("run%0d_pc", k), pc, exp_pc);
         chk($sformatf("run%0d_flush", k), {31'b0, flush}, 32'h0);
      end

      foreach (tbl[i]) begin
         v = tbl[i];
         chk($sformatf("v%0d_ready_pre", i), {31'b0, brReady}, 32'h1);
         apply(v);
         tick();
         idle();
         if (!v.etk) begin
            if (!v.stl) exp_pc += 32'h4;
            chk($sformatf("v%0d_pc", i), pc, exp_pc);
            chk($sformatf("v%0d_taken", i), {31'b0, taken}, 32'h0);
            chk($sformatf("v%0d_flush", i), {31'b0, flush}, 32'h0);
            chk($sformatf("v%0d_mis", i), {31'b0, misaligned}, 32'h0);
            chk($sformatf("v%0d_link", i), linkAddr, v.elink);
         end else if (!v.emis) begin
            exp_pc = v.etgt;
            chk($sformatf("v%0d_pc", i), pc, exp_pc);
            chk($sformatf("v%0d_flush", i), {31'b0, flush}, 32'h1);
            chk($sformatf("v%0d_taken", i), {31'b0, taken}, 32'h1);
            chk($sformatf("v%0d_ready", i), {31'b0, brReady}, 32'h0);
            chk($sformatf("v%0d_link", i), linkAddr, v.elink);
            tick();
            chk($sformatf("v%0d_post_flush", i), {31'b0, flush}, 32'h0);
            chk($sformatf("v%0d_post_ready", i), {31'b0, brReady}, 32'h1);
            chk($sformatf("v%0d_post_pc", i), pc, exp_pc);
         end else begin
            chk($sformatf("v%0d_trap_pc", i), pc, exp_pc);
            chk($sformatf("v%0d_trap_flush", i), {31'b0, flush}, 32'h1);
            chk($sformatf("v%0d_trap_taken", i), {31'b0, taken}, 32'h1);
            chk($sformatf("v%0d_trap_mis", i), {31'b0, misaligned}, 32'h1);
            chk($sformatf("v%0d_trap_ready", i), {31'b0, brReady}, 32'h0);
            chk($sformatf("v%0d_trap_link", i), linkAddr, v.elink);
            // a request presented while trapped must be ignored
            brValid = 1; jump = 1; brPC = 32'h40; offset = 32'h40;
            tick();
            idle();
            chk($sformatf("v%0d_hold_flush", i), {31'b0, flush}, 32'h0);
            chk($sformatf("v%0d_hold_mis", i), {31'b0, misaligned}, 32'h1);
            chk($sformatf("v%0d_hold_pc", i), pc, exp_pc);
            chk($sformatf("v%0d_hold_link", i), linkAddr, v.elink);
            trapAck = 1;
            tick();
            trapAck = 0;
            chk($sformatf("v%0d_ack_mis", i), {31'b0, misaligned}, 32'h0);
            chk($sformatf("v%0d_ack_ready", i), {31'b0, brReady}, 32'h1);
            chk($sformatf("v%0d_ack_pc", i), pc, exp_pc);
         end
      end

      // reset asserted during REDIRECT abandons it
      brValid = 1; jump = 1; brPC = 32'h1000; offset = 32'h20;
      tick();
      idle();
      chk("rr_pc", pc, 32'h1020);
      chk("rr_flush", {31'b0, flush}, 32'h1);
      #2 nReset = 0;
      #1;
      chk("rr_rst_pc", pc, 32'h0);
      chk("rr_rst_flush", {31'b0, flush}, 32'h0);
      chk("rr_rst_ready", {31'b0, brReady}, 32'h1);
      chk("rr_rst_link", linkAddr, 32'h0);
      #2 nReset = 1;
      tick();
      chk("rr_rel_pc", pc, 32'h4);
      chk("rr_rel_flush", {31'b0, flush}, 32'h0);
      chk("rr_rel_taken", {31'b0, taken}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
